// File: rtl/sipo_receiver.sv
// rtl/sipo_receiver.sv - serial-in parallel-out frame receiver with holding register
// Frames start on s_start; the completed word is handed off through an out_valid/out_ready register.
module sipo_receiver #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             s_valid,
   input  logic             s_start,
   input  logic             L_R,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             overrun,
   output logic             abort
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [WIDTH-1:0] first_word, shifted;
   logic [CW-1:0]    count, count_nxt;
   logic             lr, lr_nxt;
   logic             complete;
   logic             abort_nxt;

   // A new frame starts from a cleared register, so bit 0 lands at the end chosen by L_R.
   assign first_word = L_R ? {{(WIDTH-1){1'b0}}, sin} : {sin, {(WIDTH-1){1'b0}}};
   assign shifted    = lr  ? {shreg[WIDTH-2:0], sin}  : {sin, shreg[WIDTH-1:1]};

   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      count_nxt = count;
      lr_nxt    = lr;
      complete  = 1'b0;
      abort_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (s_valid && s_start) begin
               shreg_nxt = first_word;
               count_nxt = CW'(1);
               lr_nxt    = L_R;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (s_valid) begin
               if (s_start) begin
                  shreg_nxt = first_word;
                  count_nxt = CW'(1);
                  lr_nxt    = L_R;
                  abort_nxt = 1'b1;
               end else if (count == CW'(WIDTH - 1)) begin
                  complete  = 1'b1;
                  shreg_nxt = shifted;
                  count_nxt = '0;
                  state_nxt = IDLE;
               end else begin
                  shreg_nxt = shifted;
                  count_nxt = count + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg     <= '0;
         count     <= '0;
         lr        <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         abort     <= 1'b0;
      end else begin
         shreg <= shreg_nxt;
         count <= count_nxt;
         lr    <= lr_nxt;
         abort <= abort_nxt;
         // A word completing while the previous one is still held and not taken is dropped.
         if (complete) begin
            if (!out_valid || out_ready) begin
               out       <= shifted;
               out_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign busy = (state == SHIFT);

endmodule

// File: tb/tb_sipo_receiver.sv
// tb/tb_sipo_receiver.sv - self-checking bench for sipo_receiver
// A bit-list model predicts every output each cycle; directed frames pin it with literal words.
module tb_sipo_receiver;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             sin = 1'b0;
   logic             s_valid = 1'b0;
   logic             s_start = 1'b0;
   logic             L_R = 1'b0;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             busy;
   logic             overrun;
   logic             abort;

   int checks = 0;
   int failures = 0;
   int abort_seen = 0;

   sipo_receiver #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .sin(sin), .s_valid(s_valid), .s_start(s_start),
      .L_R(L_R), .out(out), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .overrun(overrun), .abort(abort)
   );

   always #5 clk = ~clk;

   bit               bits[$];
   bit               m_busy = 1'b0;
   bit               m_lr = 1'b0;
   bit               m_done;
   bit               model_ok = 1'b0;
   int               m_word;
   logic [WIDTH-1:0] exp_out = '0;
   logic             exp_valid = 1'b0;
   logic             exp_overrun = 1'b0;
   logic             exp_abort = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: collect the frame's bits, then place bit i by arithmetic on the latched order.
   always @(posedge clk) begin
      m_done = 1'b0;
      m_word = 0;
      if (rst) begin
         bits.delete();
         m_busy      = 1'b0;
         exp_out     = '0;
         exp_valid   = 1'b0;
         exp_overrun = 1'b0;
         exp_abort   = 1'b0;
         model_ok    = 1'b1;
      end else begin
         exp_abort = 1'b0;
         if (s_valid) begin
            if (s_start) begin
               if (m_busy) exp_abort = 1'b1;
               bits.delete();
               bits.push_back(sin);
               m_lr   = L_R;
               m_busy = 1'b1;
            end else if (m_busy) begin
               bits.push_back(sin);
            end
            if (m_busy && bits.size() == WIDTH) begin
               m_done = 1'b1;
               for (int i = 0; i < WIDTH; i++)
                  m_word = m_word | (int'(bits[i]) << (m_lr ? (WIDTH - 1 - i) : i));
               bits.delete();
               m_busy = 1'b0;
            end
         end
         if (m_done) begin
            if (!exp_valid || out_ready) begin
               exp_out   = m_word[WIDTH-1:0];
               exp_valid = 1'b1;
            end else begin
               exp_overrun = 1'b1;
            end
         end else if (exp_valid && out_ready) begin
            exp_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("model_out", 32'(out), 32'(exp_out));
         chk("model_out_valid", 32'(out_valid), 32'(exp_valid));
         chk("model_busy", 32'(busy), 32'(m_busy));
         chk("model_overrun", 32'(overrun), 32'(exp_overrun));
         chk("model_abort", 32'(abort), 32'(exp_abort));
         if (abort === 1'b1) abort_seen++;
      end
   end

   task automatic drive(input logic sv, input logic st, input logic b, input logic lr, input logic rdy);
      @(negedge clk);
      s_valid   = sv;
      s_start   = st;
      sin       = b;
      L_R       = lr;
      out_ready = rdy;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst     = 1'b1;
      s_valid = 1'b0;
      s_start = 1'b0;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   // seq[7] is sent first; from bit index toggle_after on, L_R is flipped to show it is ignored.
   task automatic send_frame(input logic [7:0] seq, input logic lr, input logic rdy,
                             input logic last_rdy, input int toggle_after, input int gap);
      for (int i = 0; i < 8; i++) begin
         logic lrv;
         lrv = (toggle_after >= 0 && i >= toggle_after) ? ~lr : lr;
         drive(1'b1, (i == 0), seq[7-i], lrv, (i == 7) ? last_rdy : rdy);
         for (int g = 0; g < gap; g++)
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lrv, rdy);
      end
   endtask

   initial begin
      logic [7:0] seq;
      do_reset(2);
      chk("reset_out", 32'(out), 32'h0);
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_overrun", 32'(overrun), 32'h0);
      chk("reset_abort", 32'(abort), 32'h0);

      repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("idle_ignores_bits", 32'(busy), 32'h0);

      send_frame(8'b11110000, 1'b1, 1'b1, 1'b1, -1, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("msb_first_out", 32'(out), 32'hF0);
      chk("msb_first_valid", 32'(out_valid), 32'h1);
      chk("msb_first_busy", 32'(busy), 32'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("handshake_clears_valid", 32'(out_valid), 32'h0);
      chk("handshake_keeps_out", 32'(out), 32'hF0);

      send_frame(8'b11110000, 1'b0, 1'b1, 1'b1, -1, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lsb_first_out", 32'(out), 32'h0F);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'b11110000, 1'b0, 1'b1, 1'b1, 3, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("lr_toggle_ignored", 32'(out), 32'h0F);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      send_frame(8'b10110010, 1'b0, 1'b0, 1'b0, -1, 2);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("gapped_frame_out", 32'(out), 32'h4D);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      send_frame(8'b11110000, 1'b1, 1'b0, 1'b0, -1, 0);
      send_frame(8'b11110000, 1'b0, 1'b0, 1'b0, -1, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("overrun_keeps_out", 32'(out), 32'hF0);
      chk("overrun_set", 32'(overrun), 32'h1);
      chk("overrun_valid_held", 32'(out_valid), 32'h1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("overrun_valid_drops", 32'(out_valid), 32'h0);
      chk("overrun_sticky", 32'(overrun), 32'h1);
      do_reset(1);
      chk("overrun_cleared_by_rst", 32'(overrun), 32'h0);

      abort_seen = 0;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      send_frame(8'b10100101, 1'b1, 1'b1, 1'b1, -1, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("abort_frame_out", 32'(out), 32'hA5);
      chk("abort_pulse_count", 32'(abort_seen), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      seq = 8'b11011000;
      for (int i = 0; i < 5; i++) drive(1'b1, (i == 0), seq[7-i], 1'b1, 1'b0);
      do_reset(1);
      chk("midframe_rst_busy", 32'(busy), 32'h0);
      chk("midframe_rst_out", 32'(out), 32'h0);
      chk("midframe_rst_valid", 32'(out_valid), 32'h0);
      send_frame(8'b00111100, 1'b1, 1'b1, 1'b1, -1, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("after_rst_out", 32'(out), 32'h3C);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      send_frame(8'b00010010, 1'b1, 1'b0, 1'b0, -1, 0);
      seq = 8'b00110100;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, (i == 0), seq[7-i], 1'b1, (i == 7));
         if (i == 0) begin
            chk("b2b_first_out", 32'(out), 32'h12);
            chk("b2b_first_valid", 32'(out_valid), 32'h1);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("b2b_second_out", 32'(out), 32'h34);
      chk("b2b_second_valid", 32'(out_valid), 32'h1);
      chk("b2b_no_overrun", 32'(overrun), 32'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
